// File: rtl/clockwork_affine_pkg.sv
// Shared types for the affine iteration controllers and their address
// generators.
//   coord_t  : unsigned 16-bit iteration coordinate
//   stride_t : signed 16-bit per-dimension stride
//   acc_t    : signed 32-bit affine accumulator
// term_product() forms one stride*coord term. The coordinate is
// zero-extended before the signed multiply so a large coordinate is never
// read as a negative one.
package clockwork_affine_pkg;

  typedef logic        [15:0] coord_t;
  typedef logic signed [15:0] stride_t;
  typedef logic signed [31:0] acc_t;

  localparam int DIMS_MAX = 4;

  function automatic acc_t term_product(input stride_t stride, input coord_t coord);
    acc_t s_ext;
    acc_t c_ext;
    s_ext = acc_t'(stride);
    c_ext = acc_t'($signed({1'b0, coord}));
    return s_ext * c_ext;
  endfunction

endpackage

// File: rtl/affine_bank_addr_gen_if.sv
// Coordinate-in / bank-port-out bundle for affine_bank_addr_gen.
//   d         : DIMS unsigned coordinates, d[0] outermost
//   valid     : coordinate valid
//   bank_en   : address strobe to the bank
//   bank_addr : bank word address
// master = controller side (drives d/valid), slave = address generator.
interface affine_bank_addr_gen_if
  import clockwork_affine_pkg::*;
#(
  parameter int DIMS   = 3,
  parameter int ADDR_W = 12
);

  coord_t [DIMS-1:0] d;
  logic              valid;
  logic              bank_en;
  logic [ADDR_W-1:0] bank_addr;

  modport master (output d, output valid, input bank_en, input bank_addr);
  modport slave  (input d, input valid, output bank_en, output bank_addr);

endinterface

// File: rtl/affine_bank_addr_gen_term_mul.sv
// affine_term_mul: one registered stride*coord product (pipeline stage 1).
//   clk, rst : clock, synchronous active-high reset
//   en       : capture enable (coordinate valid)
//   coord    : unsigned coordinate
//   prod     : registered signed 32-bit product
module affine_term_mul
  import clockwork_affine_pkg::*;
#(
  parameter stride_t STRIDE = 16'sd0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  coord_t coord,
  output acc_t   prod
);

  acc_t prod_d;
  acc_t prod_q;

  always_comb begin
    prod_d = prod_q;
    if (en) begin
      prod_d = term_product(STRIDE, coord);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/affine_bank_addr_gen.sv
// affine_bank_addr_gen: maps affine iteration points to bank addresses,
//   addr = (OFFSET + S0*d[0] + S1*d[1] + S2*d[2]) mod DEPTH,
// two-cycle pipeline, one op per cycle, no backpressure.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush     : drops every in-flight point (counter and flags kept)
//   bus       : slave side of affine_bank_addr_gen_if (d/valid in,
//               bank_en/bank_addr out)
//   op_count  : strobes issued since reset, saturating
//   done      : sticky, set once op_count reaches NUM_OPS
//   oob       : sticky out-of-range flag
// Optional feature: define AFFINE_BANK_ADDR_GEN_BOUNDS_CHECK_EN to flag sums
// outside [0, DEPTH); otherwise oob is tied low and no compare is built.
// Supports DIMS of 1 to 3.
module affine_bank_addr_gen
  import clockwork_affine_pkg::*;
#(
  parameter int          DIMS    = 3,
  parameter int          DEPTH   = 4096,
  parameter int          ADDR_W  = $clog2(DEPTH),
  parameter acc_t        OFFSET  = 32'sd0,
  parameter stride_t     S0      = 16'sd0,
  parameter stride_t     S1      = 16'sd64,
  parameter stride_t     S2      = 16'sd1,
  parameter logic [31:0] NUM_OPS = 32'd4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  affine_bank_addr_gen_if.slave bus,
  output logic [31:0]          op_count,
  output logic                 done,
  output logic                 oob
);

  acc_t prod [DIMS];

  for (genvar i = 0; i < DIMS; i++) begin : g_term
    localparam stride_t STRIDE = (i == 0) ? S0 : ((i == 1) ? S1 : S2);
    affine_term_mul #(.STRIDE(STRIDE)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .en    (bus.valid),
      .coord (bus.d[i]),
      .prod  (prod[i])
    );
  end

  logic              s1_vld_d, s1_vld_q;
  logic              en_d, en_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       cnt_d, cnt_q;
  logic              done_d, done_q;
  acc_t              sum_c;

  always_comb begin
    s1_vld_d = bus.valid & ~flush;
    sum_c    = OFFSET;
    for (int i = 0; i < DIMS; i++) begin
      sum_c = sum_c + prod[i];
    end
    en_d   = s1_vld_q & ~flush;
    // Truncation is the modulo-DEPTH wrap, negative sums included.
    addr_d = en_d ? sum_c[ADDR_W-1:0] : addr_q;
    cnt_d  = (en_d && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
    // cnt_d rather than cnt_q so done rises with the strobe that completes the sweep.
    done_d = done_q | (cnt_d >= NUM_OPS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

`ifdef AFFINE_BANK_ADDR_GEN_BOUNDS_CHECK_EN
  logic oob_d, oob_q;

  always_comb begin
    oob_d = oob_q | (en_d & ((sum_c < 0) | (sum_c >= acc_t'(DEPTH))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oob_q <= 1'b0;
    end else begin
      oob_q <= oob_d;
    end
  end

  assign oob = oob_q;
`else
  logic sum_hi_unused;
  assign sum_hi_unused = ^sum_c[31:ADDR_W];
  assign oob           = 1'b0;
`endif

  assign bus.bank_en   = en_q;
  assign bus.bank_addr = addr_q;
  assign op_count      = cnt_q;
  assign done          = done_q;

endmodule
